uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered serial transmitter fed by a 9-bit {strobe, byte} bus; frames are start, 8 data LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [8:0] uart_in,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int DATA_W = 8;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              bit_done;
  logic              pop;
  logic              push;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  assign bit_done  = (bit_cnt == CNT_LAST);
  assign fifo_full = (count == CNT_FULL);
  assign busy      = (count != '0) || (state != S_IDLE);
  // The head byte leaves the FIFO either from IDLE or straight out of a finishing stop bit.
  assign pop  = (count != '0) && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
  assign push = uart_in[8] && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= uart_in[DATA_W-1:0];
    if (pop)  shift_reg   <= mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (uart_in[8] && !push) overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            state <= S_START;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= even_parity(shift_reg);
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            state   <= S_STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (pop) begin
              state <= S_START;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          bit_cnt <= '0;
          tx      <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed table, hand-written reset corners and random strobe traffic for uart_tx,
// compared cycle by cycle against a frame-timing model and a line decoder.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;
  localparam int MAXS  = 16;
  localparam int MAXK  = 4096;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] uart_in = 9'h000;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .uart_in  (uart_in),
    .tx       (tx),
    .busy     (busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_passed = 0;

  int         s_n;
  int         s_t [MAXS];
  logic [7:0] s_v [MAXS];
  bit         m_acc [MAXS];
  int         m_start [MAXS];
  int         m_end [MAXS];
  int         e_n;
  logic [7:0] e_v [MAXS];
  logic       tx_w [MAXK];

  typedef struct {
    string      name;
    int         n;
    int         t [6];
    logic [7:0] d [6];
    int         n_tx;
    logic [7:0] x [6];
    int         exp_busy;
    bit         exp_ovf;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, want);
  endtask

  task automatic do_reset();
    uart_in = 9'h000;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Frame scheduler: a byte starts one edge after it is written, or when the previous frame ends.
  task automatic model_build();
    int last_end;
    int occ;
    bit pop;
    last_end = 0;
    for (int i = 0; i < s_n; i++) begin
      occ = 0;
      pop = 1'b0;
      for (int j = 0; j < i; j++)
        if (m_acc[j]) begin
          if (m_start[j] >= s_t[i]) occ++;
          if (m_start[j] == s_t[i]) pop = 1'b1;
        end
      m_acc[i]   = !((occ >= DEPTH) && !pop);
      m_start[i] = 0;
      m_end[i]   = 0;
      if (m_acc[i]) begin
        m_start[i] = (s_t[i] + 1 > last_end) ? s_t[i] + 1 : last_end;
        m_end[i]   = m_start[i] + FRAME;
        last_end   = m_end[i];
      end
    end
  endtask

  function automatic logic exp_tx(input int k);
    int b;
    for (int i = 0; i < s_n; i++)
      if (m_acc[i] && k >= m_start[i] && k < m_end[i]) begin
        b = (k - m_start[i]) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return s_v[i][b-1];
        if (FB == 11 && b == 9) return ^s_v[i];
        return 1'b1;
      end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int k);
    for (int i = 0; i < s_n; i++)
      if (m_acc[i] && s_t[i] <= k && k < m_end[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_full(input int k);
    int c;
    c = 0;
    for (int i = 0; i < s_n; i++)
      if (m_acc[i] && s_t[i] <= k && k < m_start[i]) c++;
    return (c == DEPTH);
  endfunction

  function automatic logic exp_ovf(input int k);
    for (int i = 0; i < s_n; i++)
      if (!m_acc[i] && s_t[i] <= k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_scenario(input string name, output int busy_cnt, output logic ovf_last);
    int         len;
    int         bad [4];
    int         bk [4];
    logic       ba [4];
    logic       be [4];
    logic       act [4];
    logic       want [4];
    string      sig [4];
    int         nd;
    int         k;
    int         first_bad;
    logic [7:0] db;
    sig = '{"tx", "busy", "fifo_full", "overflow"};
    do_reset();
    check({name, "_reset_busy"}, int'(busy), 0);
    check({name, "_reset_overflow"}, int'(overflow), 0);
    model_build();
    len = s_t[s_n-1] + 2;
    for (int i = 0; i < s_n; i++)
      if (m_acc[i] && m_end[i] + 2 * CPB > len) len = m_end[i] + 2 * CPB;
    if (len > MAXK) len = MAXK;
    for (int q = 0; q < 4; q++) begin
      bad[q] = 0; bk[q] = 0; ba[q] = 1'b0; be[q] = 1'b0;
    end
    busy_cnt = 0;
    for (int kk = 0; kk < len; kk++) begin
      uart_in = 9'h000;
      for (int i = 0; i < s_n; i++)
        if (s_t[i] == kk) uart_in = {1'b1, s_v[i]};
      @(posedge clock);
      #1;
      uart_in = 9'h000;
      tx_w[kk] = tx;
      act[0] = tx;     act[1] = busy;         act[2] = fifo_full;    act[3] = overflow;
      want[0] = exp_tx(kk); want[1] = exp_busy(kk); want[2] = exp_full(kk); want[3] = exp_ovf(kk);
      for (int q = 0; q < 4; q++)
        if (act[q] !== want[q]) begin
          if (bad[q] == 0) begin
            bk[q] = kk; ba[q] = act[q]; be[q] = want[q];
          end
          bad[q]++;
        end
      if (busy === 1'b1) busy_cnt++;
    end
    ovf_last = overflow;
    for (int q = 0; q < 4; q++) begin
      n_checks++;
      if (bad[q] == 0) n_passed++;
      else $display("FAIL %s_%s_wave: cycle %0d got %b want %b (%0d bad cycles)",
                    name, sig[q], bk[q], ba[q], be[q], bad[q]);
    end
    // Independent line decoder: mid-bit sampling from each falling start edge.
    nd = 0;
    k = 0;
    first_bad = -1;
    while (k + CPB * 9 + CPB / 2 < len) begin
      if (tx_w[k] == 1'b0) begin
        for (int b = 0; b < 8; b++) db[b] = tx_w[k + CPB * (1 + b) + CPB / 2];
        if (nd < MAXS) begin
          if (first_bad < 0 && (nd >= e_n || db != e_v[nd])) first_bad = nd;
          nd++;
        end
        k += FRAME;
      end else begin
        k++;
      end
    end
    check({name, "_decoded_count"}, nd, e_n);
    check({name, "_decoded_first_bad_index"}, first_bad, -1);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int   bc;
    logic ov;
    int   bad;
    int   t;

    vecs[0] = '{name:"single_55", n:1, t:'{0,0,0,0,0,0},
                d:'{8'h55,8'h00,8'h00,8'h00,8'h00,8'h00}, n_tx:1,
                x:'{8'h55,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_busy:FRAME+1, exp_ovf:1'b0};
    vecs[1] = '{name:"pair_41_42", n:2, t:'{0,1,0,0,0,0},
                d:'{8'h41,8'h42,8'h00,8'h00,8'h00,8'h00}, n_tx:2,
                x:'{8'h41,8'h42,8'h00,8'h00,8'h00,8'h00}, exp_busy:2*FRAME+1, exp_ovf:1'b0};
    vecs[2] = '{name:"burst6_overflow", n:6, t:'{0,1,2,3,4,5},
                d:'{8'h01,8'h02,8'h03,8'h04,8'h05,8'h06}, n_tx:5,
                x:'{8'h01,8'h02,8'h03,8'h04,8'h05,8'h00}, exp_busy:5*FRAME+1, exp_ovf:1'b1};
    vecs[3] = '{name:"gap_far", n:2, t:'{0,FRAME+5,0,0,0,0},
                d:'{8'hA5,8'h3C,8'h00,8'h00,8'h00,8'h00}, n_tx:2,
                x:'{8'hA5,8'h3C,8'h00,8'h00,8'h00,8'h00}, exp_busy:2*FRAME+2, exp_ovf:1'b0};
    vecs[4] = '{name:"strobe_at_stop_end", n:2, t:'{0,FRAME+1,0,0,0,0},
                d:'{8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00}, n_tx:2,
                x:'{8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_busy:2*FRAME+2, exp_ovf:1'b0};
    vecs[5] = '{name:"strobe_mid_frame", n:2, t:'{0,10,0,0,0,0},
                d:'{8'h81,8'h7E,8'h00,8'h00,8'h00,8'h00}, n_tx:2,
                x:'{8'h81,8'h7E,8'h00,8'h00,8'h00,8'h00}, exp_busy:2*FRAME+1, exp_ovf:1'b0};
    vecs[6] = '{name:"write_full_with_pop", n:6, t:'{0,1,2,3,4,FRAME+1},
                d:'{8'h11,8'h22,8'h33,8'h44,8'h55,8'h66}, n_tx:6,
                x:'{8'h11,8'h22,8'h33,8'h44,8'h55,8'h66}, exp_busy:6*FRAME+1, exp_ovf:1'b0};
    vecs[7] = '{name:"bytes_07_03", n:2, t:'{0,1,0,0,0,0},
                d:'{8'h07,8'h03,8'h00,8'h00,8'h00,8'h00}, n_tx:2,
                x:'{8'h07,8'h03,8'h00,8'h00,8'h00,8'h00}, exp_busy:2*FRAME+1, exp_ovf:1'b0};

    do_reset();
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_fifo_full", int'(fifo_full), 0);
    check("reset_overflow", int'(overflow), 0);
    @(posedge clock);
    #1;
    check("idle_tx", int'(tx), 1);
    check("idle_busy", int'(busy), 0);

    reset_n = 1'b0;
    uart_in = {1'b1, 8'hAA};
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    uart_in = 9'h000;
    bad = 0;
    repeat (FRAME) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("strobe_in_reset_bad_cycles", bad, 0);

    do_reset();
    uart_in = {1'b1, 8'h0F};
    @(posedge clock);
    #1;
    uart_in = {1'b1, 8'hF0};
    @(posedge clock);
    #1;
    uart_in = 9'h000;
    repeat (16) begin
      @(posedge clock);
      #1;
    end
    check("abort_b3_tx_before", int'(tx), 1);
    check("abort_b3_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("abort_b3_tx", int'(tx), 1);
    check("abort_b3_busy", int'(busy), 0);
    check("abort_b3_fifo_full", int'(fifo_full), 0);
    check("abort_b3_overflow", int'(overflow), 0);
    reset_n = 1'b1;
    bad = 0;
    repeat (3 * FRAME) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_b3_quiet_bad_cycles", bad, 0);

    do_reset();
    uart_in = {1'b1, 8'h0F};
    @(posedge clock);
    #1;
    uart_in = 9'h000;
    repeat (21) begin
      @(posedge clock);
      #1;
    end
    check("abort_b4_tx_before", int'(tx), 0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("abort_b4_tx", int'(tx), 1);
    check("abort_b4_busy", int'(busy), 0);
    reset_n = 1'b1;
    bad = 0;
    repeat (2 * FRAME) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_b4_quiet_bad_cycles", bad, 0);

    for (int v = 0; v < 8; v++) begin
      s_n = vecs[v].n;
      for (int i = 0; i < s_n; i++) begin
        s_t[i] = vecs[v].t[i];
        s_v[i] = vecs[v].d[i];
      end
      e_n = vecs[v].n_tx;
      for (int i = 0; i < e_n; i++) e_v[i] = vecs[v].x[i];
      run_scenario(vecs[v].name, bc, ov);
      check({vecs[v].name, "_busy_cycles"}, bc, vecs[v].exp_busy);
      check({vecs[v].name, "_overflow_end"}, int'(ov), int'(vecs[v].exp_ovf));
    end

    for (int r = 0; r < 8; r++) begin
      s_n = $urandom_range(4, 12);
      t = $urandom_range(0, 3);
      for (int i = 0; i < s_n; i++) begin
        s_t[i] = t;
        s_v[i] = 8'($urandom);
        t += ($urandom_range(0, 3) == 0) ? $urandom_range(FRAME / 2, 2 * FRAME) : $urandom_range(1, 3);
      end
      model_build();
      e_n = 0;
      for (int i = 0; i < s_n; i++)
        if (m_acc[i]) begin
          e_v[e_n] = s_v[i];
          e_n++;
        end
      run_scenario($sformatf("rand%0d", r), bc, ov);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
